phase_sequencer: RTL and testbench
==================================

// Module: phase_sequencer
// PURPOSE
//  Five-phase instruction sequencer for the core: steps P1 fetch, P2 decode/reg read, P3 ALU,
//  P4 memory, P5 writeback/PC update. Emits per-phase strobes to the datapath, including
//  pc_update (drives PC_load_in of the jump-judgement logic in P5). Handles run/stop, HLT,
//  memory wait states and a wait-timeout error.
// PARAMETERS
//  CNT_W     16  width of retired-instruction counter instr_cnt
//  WAIT_MAX  15  max consecutive !mem_ready cycles in P1/P4 before ERR; 1..2**8-1
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      synchronous reset, active-high
//  exec        in   1      run/stop pulse (1 cycle)
//  halt_dec    in   1      decoded instruction is HLT (valid P2)
//  is_load     in   1      decoded LD (valid P2..P5)
//  is_store    in   1      decoded ST (valid P2..P5)
//  writes_reg  in   1      instruction writes register file
//  writes_flag in   1      instruction updates SZCV
//  mem_ready   in   1      memory access complete this cycle
//  phase       out  5      one-hot {P5..P1}, 0 when not executing
//  ir_we       out  1      latch instruction register
//  flag_we     out  1      write FLAG register
//  mem_re      out  1      memory read request
//  mem_we      out  1      memory write request
//  reg_we      out  1      register file write
//  pc_update   out  1      PC load/increment strobe (to PC_load_in)
//  running     out  1      state in P1..P5
//  halted      out  1      state HALT
//  err         out  1      state ERR
//  instr_cnt   out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  - States: IDLE, P1..P5, HALT, ERR. State and instr_cnt registered; strobes Moore/Mealy
//    decode of state and same-cycle inputs, no extra latency.
//  - Reset: state IDLE, stop_req 0, wait_cnt 0, instr_cnt 0; all outputs 0.
//  - IDLE: exec -> P1 next cycle.
//  - P1: mem_re=1 and ir_we=mem_ready; mem_ready -> P2, else hold.
//  - P2: halt_dec -> HALT (no P3..P5, instr_cnt unchanged); else -> P3.
//  - P3: flag_we=writes_flag; -> P4.
//  - P4: load: mem_re=1; store: mem_we=1; hold until mem_ready. Neither: one cycle, mem_ready
//    ignored. is_load&is_store together: treated as store.
//  - P5: reg_we=writes_reg; pc_update=1; instr_cnt+=1 (wraps at 2**CNT_W); -> IDLE if stop_req
//    or exec this cycle, else P1. stop_req cleared on leaving P5.
//  - exec while running (P1..P4): sets stop_req; instruction always completes through P5;
//    never aborts mid-instruction.
//  - HALT: halted=1; exec -> IDLE. Other inputs ignored.
//  - Wait timeout: wait_cnt counts consecutive P1/P4 wait cycles; cleared on mem_ready or
//    phase change. wait_cnt==WAIT_MAX with !mem_ready -> ERR; strobes drop in ERR.
//  - ERR: err=1; exits only via rst.
//  - rst mid-instruction: immediate return to reset values; no partial strobes next cycle.
//  - phase, ir_we..pc_update are 0 in IDLE, HALT, ERR.
// CONFIGURATION
//  PHASE_SEQ_STEP_EN defined: adds input `step` (1 bit, after exec). step in IDLE runs exactly
//   one instruction (P1..P5) then returns to IDLE; step while running ignored; exec wins when
//   exec and step coincide in IDLE. Not defined: no step port, exec is the only start.
// TESTING
//  1 rst, exec, mem_ready=1, plain ALU op -> phase 00001,00010,00100,01000,10000, repeat;
//    pc_update once per 5 cycles; instr_cnt 1 after first P5.
//  2 LD with mem_ready low 3 cycles in P4 -> P4 held 4 cycles, mem_re high throughout,
//    reg_we in P5, instr_cnt +1.
//  3 halt_dec=1 in P2 -> HALT next cycle, halted=1, instr_cnt unchanged; exec -> IDLE.
//  4 exec in P3 -> P4, P5 complete, then IDLE; pc_update seen exactly once.
//  5 mem_ready=0 in P1, WAIT_MAX=15 -> err=1 after 16th wait cycle; only rst clears.
//  6 CNT_W=4, 16 instructions -> instr_cnt wraps 15->0; with STEP_EN, step -> one instr.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// Sequencer <-> datapath bundle for phase_sequencer.
// The `step` input exists only when PHASE_SEQ_STEP_EN is defined.
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             exec;
`ifdef PHASE_SEQ_STEP_EN
  logic             step;
`endif
  logic             halt_dec;
  logic             is_load;
  logic             is_store;
  logic             writes_reg;
  logic             writes_flag;
  logic             mem_ready;
  logic [4:0]       phase;
  logic             ir_we;
  logic             flag_we;
  logic             mem_re;
  logic             mem_we;
  logic             reg_we;
  logic             pc_update;
  logic             running;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  exec,
`ifdef PHASE_SEQ_STEP_EN
    input  step,
`endif
    input  halt_dec, is_load, is_store, writes_reg, writes_flag, mem_ready,
    output phase, ir_we, flag_we, mem_re, mem_we, reg_we, pc_update,
    output running, halted, err, instr_cnt
  );

  modport slave (
    output exec,
`ifdef PHASE_SEQ_STEP_EN
    output step,
`endif
    output halt_dec, is_load, is_store, writes_reg, writes_flag, mem_ready,
    input  phase, ir_we, flag_we, mem_re, mem_we, reg_we, pc_update,
    input  running, halted, err, instr_cnt
  );
endinterface

// File: rtl/phase_sequencer.sv
// Five-phase (fetch/decode/ALU/memory/writeback) instruction sequencer with run/stop,
// HLT, memory wait states and wait timeout. PHASE_SEQ_STEP_EN adds single-step start.
module phase_sequencer #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  phase_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P1   = 3'd1;
  localparam logic [2:0] S_P2   = 3'd2;
  localparam logic [2:0] S_P3   = 3'd3;
  localparam logic [2:0] S_P4   = 3'd4;
  localparam logic [2:0] S_P5   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  logic [2:0]       state, state_nxt;
  logic             stop_req, stop_req_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic [CNT_W-1:0] instr_cnt;
  logic             retire;
  logic             mem_access;
  logic             mem_wait;
  logic             start_step;

  function automatic logic [4:0] phase_onehot(input logic [2:0] s);
    logic [4:0] p;
    p = '0;
    case (s)
      S_P1:    p = 5'b00001;
      S_P2:    p = 5'b00010;
      S_P3:    p = 5'b00100;
      S_P4:    p = 5'b01000;
      S_P5:    p = 5'b10000;
      default: p = 5'b00000;
    endcase
    return p;
  endfunction

  assign mem_access = bus.is_load | bus.is_store;
  assign mem_wait   = ((state == S_P1) | ((state == S_P4) & mem_access)) & ~bus.mem_ready;

`ifdef PHASE_SEQ_STEP_EN
  assign start_step = bus.step & ~bus.exec;
`else
  assign start_step = 1'b0;
`endif

  // A single-step start simply pre-arms stop_req so P5 returns to IDLE.
  always_comb begin
    state_nxt    = state;
    stop_req_nxt = stop_req;
    wait_cnt_nxt = '0;
    retire       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.exec) begin
          state_nxt    = S_P1;
          stop_req_nxt = 1'b0;
        end else if (start_step) begin
          state_nxt    = S_P1;
          stop_req_nxt = 1'b1;
        end
      end
      S_P1: begin
        stop_req_nxt = stop_req | bus.exec;
        if (bus.mem_ready) state_nxt = S_P2;
      end
      S_P2: begin
        if (bus.halt_dec) begin
          state_nxt    = S_HALT;
          stop_req_nxt = 1'b0;
        end else begin
          state_nxt    = S_P3;
          stop_req_nxt = stop_req | bus.exec;
        end
      end
      S_P3: begin
        stop_req_nxt = stop_req | bus.exec;
        state_nxt    = S_P4;
      end
      S_P4: begin
        stop_req_nxt = stop_req | bus.exec;
        if (!mem_access || bus.mem_ready) state_nxt = S_P5;
      end
      S_P5: begin
        retire       = 1'b1;
        stop_req_nxt = 1'b0;
        state_nxt    = (stop_req | bus.exec) ? S_IDLE : S_P1;
      end
      S_HALT: begin
        if (bus.exec) state_nxt = S_IDLE;
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
    endcase
    // Timeout overrides any hold decision above; the counter only survives a stalled cycle.
    if (mem_wait) begin
      if (wait_cnt == WAIT_LIM) state_nxt = S_ERR;
      else                      wait_cnt_nxt = wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      stop_req  <= 1'b0;
      wait_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      state    <= state_nxt;
      stop_req <= stop_req_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  // Strobes decode directly from state and same-cycle inputs.
  always_comb begin
    bus.ir_we     = 1'b0;
    bus.flag_we   = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.reg_we    = 1'b0;
    bus.pc_update = 1'b0;
    case (state)
      S_P1: begin
        bus.mem_re = 1'b1;
        bus.ir_we  = bus.mem_ready;
      end
      S_P3: bus.flag_we = bus.writes_flag;
      S_P4: begin
        bus.mem_we = bus.is_store;
        bus.mem_re = bus.is_load & ~bus.is_store;
      end
      S_P5: begin
        bus.reg_we    = bus.writes_reg;
        bus.pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.phase     = phase_onehot(state);
  assign bus.running   = (state >= S_P1) && (state <= S_P5);
  assign bus.halted    = (state == S_HALT);
  assign bus.err       = (state == S_ERR);
  assign bus.instr_cnt = instr_cnt;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: vector table, directed corner sequences and
// randomized traffic against an integer-level model of the sequencing rules.
module tb_phase_sequencer;
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 15;
`ifdef PHASE_SEQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_sequencer_if #(.CNT_W(CNT_W)) bus ();
  phase_sequencer #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic rst, exec, step, halt_dec, is_load, is_store, writes_reg, writes_flag, mem_ready;
  } in_t;

  typedef struct {
    in_t        i;
    logic [4:0] ph;
    logic [5:0] sb;   // {ir_we, flag_we, mem_re, mem_we, reg_we, pc_update}
    logic [2:0] st;   // {running, halted, err}
    int         cnt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within instruction (0 = none) plus mode flags.
  int m_ph, m_wait, m_cnt;
  bit m_halt, m_err, m_stop;

  function automatic in_t mk(input logic ex, hd, ld, st, wr, wf, mr);
    in_t r;
    r.rst = 1'b0; r.exec = ex; r.step = 1'b0; r.halt_dec = hd; r.is_load = ld;
    r.is_store = st; r.writes_reg = wr; r.writes_flag = wf; r.mem_ready = mr;
    return r;
  endfunction

  function automatic in_t mkrst();
    in_t r;
    r = mk(0, 0, 0, 0, 0, 0, 0);
    r.rst = 1'b1;
    return r;
  endfunction

  function automatic vec_t mkv(input in_t i, input logic [4:0] ph, input logic [5:0] sb,
                               input logic [2:0] st, input int cnt);
    vec_t v;
    v.i = i; v.ph = ph; v.sb = sb; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t v);
    @(negedge clk);
    rst             = v.rst;
    bus.exec        = v.exec;
`ifdef PHASE_SEQ_STEP_EN
    bus.step        = v.step;
`endif
    bus.halt_dec    = v.halt_dec;
    bus.is_load     = v.is_load;
    bus.is_store    = v.is_store;
    bus.writes_reg  = v.writes_reg;
    bus.writes_flag = v.writes_flag;
    bus.mem_ready   = v.mem_ready;
    #1;
  endtask

  function automatic int act_sb();
    return int'({bus.ir_we, bus.flag_we, bus.mem_re, bus.mem_we, bus.reg_we, bus.pc_update});
  endfunction

  function automatic int act_st();
    return int'({bus.running, bus.halted, bus.err});
  endfunction

  task automatic model_check(input in_t v);
    int         exp_ph;
    logic [5:0] sb;
    exp_ph = (m_ph == 0) ? 0 : (1 << (m_ph - 1));
    sb = {m_ph == 1 && v.mem_ready,
          m_ph == 3 && v.writes_flag,
          m_ph == 1 || (m_ph == 4 && v.is_load && !v.is_store),
          m_ph == 4 && v.is_store,
          m_ph == 5 && v.writes_reg,
          m_ph == 5};
    check("phase", int'(bus.phase), exp_ph);
    check("strobes", act_sb(), int'(sb));
    check("status", act_st(), int'({m_ph != 0, m_halt, m_err}));
    check("instr_cnt", int'(bus.instr_cnt), m_cnt);
  endtask

  task automatic model_step(input in_t v);
    bit waits;
    if (v.rst) begin
      m_ph = 0; m_wait = 0; m_cnt = 0; m_halt = 0; m_err = 0; m_stop = 0;
      return;
    end
    if (m_err) return;
    if (m_halt) begin
      if (v.exec) m_halt = 0;
      return;
    end
    if (m_ph == 0) begin
      if (v.exec) begin
        m_ph = 1; m_stop = 0;
      end else if (STEP_EN && v.step) begin
        m_ph = 1; m_stop = 1;
      end
      return;
    end
    if (m_ph < 5 && v.exec) m_stop = 1;
    waits = (m_ph == 1) || (m_ph == 4 && (v.is_load || v.is_store));
    if (waits && !v.mem_ready) begin
      if (m_wait == WAIT_MAX) begin
        m_err = 1; m_ph = 0;
      end else begin
        m_wait++;
      end
      return;
    end
    m_wait = 0;
    if (m_ph == 2 && v.halt_dec) begin
      m_halt = 1; m_ph = 0; m_stop = 0;
    end else if (m_ph == 5) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_ph  = (m_stop || v.exec) ? 0 : 1;
      m_stop = 0;
    end else begin
      m_ph++;
    end
  endtask

  task automatic run_cycle(input in_t v);
    apply(v);
    model_check(v);
    model_step(v);
  endtask

  vec_t tbl[26];
  in_t  v;
  bit   low_burst;
  int   low_left;

  initial begin
    // exec, halt_dec, is_load, is_store, writes_reg, writes_flag, mem_ready
    tbl[0]  = mkv(mk(1,0,0,0,0,0,1), 5'b00000, 6'b000000, 3'b000, 0);
    tbl[1]  = mkv(mk(0,0,0,0,1,1,1), 5'b00001, 6'b101000, 3'b100, 0);
    tbl[2]  = mkv(mk(0,0,0,0,1,1,1), 5'b00010, 6'b000000, 3'b100, 0);
    tbl[3]  = mkv(mk(0,0,0,0,1,1,1), 5'b00100, 6'b010000, 3'b100, 0);
    tbl[4]  = mkv(mk(0,0,0,0,1,1,0), 5'b01000, 6'b000000, 3'b100, 0);
    tbl[5]  = mkv(mk(0,0,0,0,1,1,1), 5'b10000, 6'b000011, 3'b100, 0);
    tbl[6]  = mkv(mk(0,0,1,0,1,0,1), 5'b00001, 6'b101000, 3'b100, 1);
    tbl[7]  = mkv(mk(0,0,1,0,1,0,1), 5'b00010, 6'b000000, 3'b100, 1);
    tbl[8]  = mkv(mk(0,0,1,0,1,0,1), 5'b00100, 6'b000000, 3'b100, 1);
    tbl[9]  = mkv(mk(0,0,1,0,1,0,0), 5'b01000, 6'b001000, 3'b100, 1);
    tbl[10] = mkv(mk(0,0,1,0,1,0,0), 5'b01000, 6'b001000, 3'b100, 1);
    tbl[11] = mkv(mk(0,0,1,0,1,0,0), 5'b01000, 6'b001000, 3'b100, 1);
    tbl[12] = mkv(mk(0,0,1,0,1,0,1), 5'b01000, 6'b001000, 3'b100, 1);
    tbl[13] = mkv(mk(0,0,1,0,1,0,1), 5'b10000, 6'b000011, 3'b100, 1);
    tbl[14] = mkv(mk(0,0,1,1,0,0,1), 5'b00001, 6'b101000, 3'b100, 2);
    tbl[15] = mkv(mk(0,0,1,1,0,0,1), 5'b00010, 6'b000000, 3'b100, 2);
    tbl[16] = mkv(mk(1,0,1,1,0,0,1), 5'b00100, 6'b000000, 3'b100, 2);
    tbl[17] = mkv(mk(0,0,1,1,0,0,1), 5'b01000, 6'b000100, 3'b100, 2);
    tbl[18] = mkv(mk(0,0,1,1,0,0,1), 5'b10000, 6'b000001, 3'b100, 2);
    tbl[19] = mkv(mk(0,0,0,0,0,0,1), 5'b00000, 6'b000000, 3'b000, 3);
    tbl[20] = mkv(mk(1,0,0,0,0,0,1), 5'b00000, 6'b000000, 3'b000, 3);
    tbl[21] = mkv(mk(0,0,0,0,0,0,1), 5'b00001, 6'b101000, 3'b100, 3);
    tbl[22] = mkv(mk(0,1,0,0,0,0,1), 5'b00010, 6'b000000, 3'b100, 3);
    tbl[23] = mkv(mk(0,0,0,0,0,0,1), 5'b00000, 6'b000000, 3'b010, 3);
    tbl[24] = mkv(mk(1,0,0,0,0,0,1), 5'b00000, 6'b000000, 3'b010, 3);
    tbl[25] = mkv(mk(0,0,0,0,0,0,1), 5'b00000, 6'b000000, 3'b000, 3);

    // First reset edge brings the DUT out of X; the second cycle checks reset values.
    apply(mkrst());
    model_step(mkrst());
    run_cycle(mkrst());

    for (int k = 0; k < 26; k++) begin
      apply(tbl[k].i);
      check($sformatf("vec%0d.phase", k), int'(bus.phase), int'(tbl[k].ph));
      check($sformatf("vec%0d.strobes", k), act_sb(), int'(tbl[k].sb));
      check($sformatf("vec%0d.status", k), act_st(), int'(tbl[k].st));
      check($sformatf("vec%0d.cnt", k), int'(bus.instr_cnt), tbl[k].cnt);
      model_step(tbl[k].i);
    end

    // Fetch wait timeout: 16 stalled P1 cycles, then ERR until reset.
    run_cycle(mkrst());
    run_cycle(mk(1,0,0,0,0,0,1));
    for (int k = 1; k <= 16; k++) begin
      v = mk(0,0,0,0,0,0,0);
      apply(v);
      check($sformatf("tmo_wait%0d.err", k), int'(bus.err), 0);
      check($sformatf("tmo_wait%0d.phase", k), int'(bus.phase), 1);
      model_step(v);
    end
    for (int k = 0; k < 3; k++) begin
      v = mk(1,0,0,0,1,1,1);
      apply(v);
      check("tmo.err", int'(bus.err), 1);
      check("tmo.phase", int'(bus.phase), 0);
      check("tmo.strobes", act_sb(), 0);
      model_step(v);
    end
    run_cycle(mkrst());
    apply(mk(0,0,0,0,0,0,1));
    check("tmo_clr.err", int'(bus.err), 0);
    model_step(mk(0,0,0,0,0,0,1));

    // Reset in the middle of an instruction leaves no strobes behind.
    run_cycle(mk(1,0,0,0,1,1,1));
    run_cycle(mk(0,0,0,0,1,1,1));
    run_cycle(mk(0,0,0,0,1,1,1));
    v = mk(0,0,0,0,1,1,1);
    v.rst = 1'b1;
    run_cycle(v);
    apply(mk(0,0,1,1,1,1,1));
    check("midrst.phase", int'(bus.phase), 0);
    check("midrst.strobes", act_sb(), 0);
    check("midrst.status", act_st(), 0);
    model_step(mk(0,0,1,1,1,1,1));

    // Counter wraps after 2**CNT_W retired instructions.
    run_cycle(mkrst());
    run_cycle(mk(1,0,0,0,1,0,1));
    for (int i = 1; i <= 16; i++) begin
      for (int p = 0; p < 5; p++) run_cycle(mk(0,0,0,0,1,0,1));
      @(posedge clk);
      #1;
      check($sformatf("wrap%0d.cnt", i), int'(bus.instr_cnt), i % 16);
    end

`ifdef PHASE_SEQ_STEP_EN
    // Single step runs one instruction; step while running is ignored; exec wins.
    run_cycle(mkrst());
    v = mk(0,0,0,0,1,0,1);
    v.step = 1'b1;
    run_cycle(v);
    for (int p = 0; p < 5; p++) run_cycle(v);
    apply(mk(0,0,0,0,0,0,1));
    check("step.status", act_st(), 0);
    check("step.cnt", int'(bus.instr_cnt), 1);
    model_step(mk(0,0,0,0,0,0,1));
    v = mk(1,0,0,0,0,0,1);
    v.step = 1'b1;
    run_cycle(v);
    for (int p = 0; p < 5; p++) run_cycle(mk(0,0,0,0,0,0,1));
    apply(mk(0,0,0,0,0,0,1));
    check("exec_wins.phase", int'(bus.phase), 1);
    model_step(mk(0,0,0,0,0,0,1));
`endif

    // Randomized traffic against the model.
    run_cycle(mkrst());
    low_burst = 0;
    low_left  = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!low_burst && $urandom_range(0, 99) == 0) begin
        low_burst = 1;
        low_left  = $urandom_range(8, 20);
      end
      v = mk($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             low_burst ? 1'b0 : ($urandom_range(0, 3) != 0));
      v.step = ($urandom_range(0, 15) == 0);
      v.rst  = m_err ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
      if (low_burst) begin
        low_left--;
        if (low_left <= 0) low_burst = 0;
      end
      run_cycle(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
